buzzer_scoreboard: RTL

BUZZER_SCOREBOARD -- requirements
Module: buzzer_scoreboard

---
 rtl/buzzer_scoreboard_pkg.sv | 22 ++
 rtl/buzzer_scoreboard_timer.sv | 41 ++++
 rtl/buzzer_scoreboard.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/buzzer_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_scoreboard_pkg
// Shared definitions for the buzzer scoreboard: FSM state encodings, one-hot
// player codes, and the default win score and arm timeout.
// -----------------------------------------------------------------------------
package buzzer_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_JUDGE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PLAYER_NONE = 2'b00;
    localparam logic [1:0] PLAYER_1    = 2'b01;
    localparam logic [1:0] PLAYER_2    = 2'b10;

    localparam int DEF_WIN_SCORE = 5;
    localparam int DEF_TIMEOUT   = 1000;

endpackage

// File: rtl/buzzer_scoreboard_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Counts clk cycles while enabled; clear returns it to zero. The expired flag
// is registered and goes high on the edge where the count reaches TIMEOUT,
// then holds until clear.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous clear of count and expired flag
//   en          : count enable
//   expired     : registered, high once TIMEOUT enabled cycles have elapsed
// -----------------------------------------------------------------------------
module round_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
            // Flag on the same edge the count lands on TIMEOUT.
            if (count == CW'(TIMEOUT - 1))
                expired <= 1'b1;
        end
    end

endmodule

// File: rtl/buzzer_scoreboard.sv
// -----------------------------------------------------------------------------
// buzzer_scoreboard
// Round controller and score keeper sitting behind a two-player buzzer stage.
// Arms the buzzers on request, captures which player locked out first, applies
// the host's verdict to that player's score and declares a winner.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   led1, led2            : lockout levels from the buzzer stage
//   next_round            : host pulse, arm a new round
//   judge_ok, judge_bad   : host verdict pulses for the captured answer
//   new_game              : host pulse, clear everything back to IDLE
//   control               : 1 = buzzers live / locked, 0 = buzzer stage cleared
//   score1, score2        : player scores (unsigned, saturating)
//   answering             : one-hot captured player
//   game_over, winner     : end-of-game flag and one-hot winning player
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module buzzer_scoreboard
    import buzzer_scoreboard_pkg::*;
#(
    parameter int WIN_SCORE = DEF_WIN_SCORE,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led1,
    input  logic       led2,
    input  logic       next_round,
    input  logic       judge_ok,
    input  logic       judge_bad,
    input  logic       new_game,
    output logic       control,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] answering,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? WIN : s + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] s);
        return (s == 4'd0) ? 4'd0 : s - 4'd1;
    endfunction

    state_t     state, state_nxt;
    logic       control_nxt, game_over_nxt;
    logic [3:0] score1_nxt, score2_nxt;
    logic [1:0] answering_nxt, winner_nxt;
    logic       expired;

    // Timer runs only in ARMED and sits cleared everywhere else, so it always
    // starts from zero on round entry.
    round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_ARMED),
        .en      (state == ST_ARMED),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            control   <= 1'b0;
            score1    <= 4'd0;
            score2    <= 4'd0;
            answering <= PLAYER_NONE;
            game_over <= 1'b0;
            winner    <= PLAYER_NONE;
        end else begin
            state     <= state_nxt;
            control   <= control_nxt;
            score1    <= score1_nxt;
            score2    <= score2_nxt;
            answering <= answering_nxt;
            game_over <= game_over_nxt;
            winner    <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        control_nxt   = control;
        score1_nxt    = score1;
        score2_nxt    = score2;
        answering_nxt = answering;
        game_over_nxt = game_over;
        winner_nxt    = winner;

        if (new_game) begin
            state_nxt     = ST_IDLE;
            control_nxt   = 1'b0;
            score1_nxt    = 4'd0;
            score2_nxt    = 4'd0;
            answering_nxt = PLAYER_NONE;
            game_over_nxt = 1'b0;
            winner_nxt    = PLAYER_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (next_round) begin
                        state_nxt   = ST_ARMED;
                        control_nxt = 1'b1;
                    end
                end
                ST_ARMED: begin
                    // A buzz on the final cycle still beats the timeout;
                    // P1 wins a same-cycle tie.
                    if (led1 || led2) begin
                        state_nxt     = ST_JUDGE;
                        answering_nxt = led1 ? PLAYER_1 : PLAYER_2;
                    end else if (expired) begin
                        state_nxt   = ST_IDLE;
                        control_nxt = 1'b0;
                    end
                end
                ST_JUDGE: begin
                    if (judge_ok && !judge_bad) begin
                        state_nxt     = ST_IDLE;
                        control_nxt   = 1'b0;
                        answering_nxt = PLAYER_NONE;
                        if (answering == PLAYER_1) begin
                            score1_nxt = sat_inc(score1);
                            if (score1_nxt == WIN) begin
                                state_nxt     = ST_DONE;
                                game_over_nxt = 1'b1;
                                winner_nxt    = PLAYER_1;
                            end
                        end else begin
                            score2_nxt = sat_inc(score2);
                            if (score2_nxt == WIN) begin
                                state_nxt     = ST_DONE;
                                game_over_nxt = 1'b1;
                                winner_nxt    = PLAYER_2;
                            end
                        end
                    end else if (judge_bad && !judge_ok) begin
                        state_nxt     = ST_IDLE;
                        control_nxt   = 1'b0;
                        answering_nxt = PLAYER_NONE;
                        if (answering == PLAYER_1)
                            score1_nxt = sat_dec(score1);
                        else
                            score2_nxt = sat_dec(score2);
                    end
                end
                ST_DONE: begin
                    control_nxt = 1'b0;
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    control_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
